// File: rtl/edge_mem_pkg.sv
// Shared constants and types for the edge/bin BRAM and its arbiter.
package edge_mem_pkg;

  localparam int unsigned WIDTH     = 640;
  localparam int unsigned HEIGHT    = 480;
  localparam int unsigned NPIX      = WIDTH * HEIGHT;
  localparam int unsigned ADDR_W    = 19;
  localparam int unsigned BIN_W     = 3;
  localparam int unsigned NREQ      = 3;
  localparam int unsigned REQ_EDGE  = 0;
  localparam int unsigned REQ_TRACE = 1;
  localparam int unsigned REQ_DISP  = 2;

  typedef struct packed {
    logic [NREQ-1:0] req;
    logic            is_read;
    logic            oor;
  } tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer moves to the other requester after each grant.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  logic r_ptr;

  always_comb begin
    o_gnt = '0;
    if (i_en) begin
      if (i_req[r_ptr]) begin
        o_gnt[r_ptr] = 1'b1;
      end else if (i_req[~r_ptr]) begin
        o_gnt[~r_ptr] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr <= 1'b0;
    end else if (o_gnt[0]) begin
      r_ptr <= 1'b1;
    end else if (o_gnt[1]) begin
      r_ptr <= 1'b0;
    end
  end

endmodule

// File: rtl/edge_bram_arbiter.sv
// Single-port edge/bin BRAM arbiter: display priority with starvation limit, round-robin
// between writer and tracer, range check, and a fixed 3-cycle read return path.
module edge_bram_arbiter #(
  parameter int unsigned WIDTH      = edge_mem_pkg::WIDTH,
  parameter int unsigned HEIGHT     = edge_mem_pkg::HEIGHT,
  parameter int unsigned MAX_STARVE = 15
) (
  input  logic                                                   clk,
  input  logic                                                   rst,
  input  logic [edge_mem_pkg::NREQ-1:0]                          req_i,
  input  logic [edge_mem_pkg::NREQ-1:0]                          we_i,
  input  logic [edge_mem_pkg::NREQ-1:0][edge_mem_pkg::ADDR_W-1:0] addr_i,
  input  logic [edge_mem_pkg::NREQ-1:0][edge_mem_pkg::BIN_W-1:0]  wdata_i,
  output logic [edge_mem_pkg::NREQ-1:0]                          gnt_o,
  output logic [edge_mem_pkg::NREQ-1:0]                          rvalid_o,
  output logic [edge_mem_pkg::BIN_W-1:0]                         rdata_o,
  output logic                                                   err_o,
  output logic [edge_mem_pkg::ADDR_W-1:0]                        bram_addr_o,
  output logic                                                   bram_we_o,
  output logic [edge_mem_pkg::BIN_W-1:0]                         bram_din_o,
  input  logic [edge_mem_pkg::BIN_W-1:0]                         bram_dout_i
);
  import edge_mem_pkg::*;

  localparam int unsigned FramePix = WIDTH * HEIGHT;
  localparam int unsigned SW       = $clog2(MAX_STARVE + 1);
  localparam logic [SW-1:0] StarveMax = SW'(MAX_STARVE);

  logic [SW-1:0]     r_starve;
  logic              w_oth_req;
  logic              w_disp_win;
  logic [1:0]        w_rr_gnt;
  logic [NREQ-1:0]   w_gnt;
  logic [ADDR_W-1:0] w_addr;
  logic              w_we;
  logic [BIN_W-1:0]  w_din;
  logic              w_oor;
  tag_t              r_tag1;
  tag_t              r_tag2;

  assign w_oth_req  = req_i[REQ_EDGE] | req_i[REQ_TRACE];
  // Display loses only once the writer/tracer has waited through MAX_STARVE display grants.
  assign w_disp_win = req_i[REQ_DISP] & ~((r_starve == StarveMax) & w_oth_req);

  rr_arb2 u_rr_arb2 (
    .clk   (clk),
    .rst   (rst),
    .i_en  (~w_disp_win & ~rst),
    .i_req (req_i[1:0]),
    .o_gnt (w_rr_gnt)
  );

  assign w_gnt = w_disp_win ? 3'b100 : {1'b0, w_rr_gnt};
  assign gnt_o = rst ? '0 : w_gnt;

  always_comb begin
    w_addr = '0;
    w_we   = 1'b0;
    w_din  = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        w_addr = addr_i[k];
        w_we   = we_i[k];
        w_din  = wdata_i[k];
      end
    end
  end

  assign w_oor = (w_addr >= ADDR_W'(FramePix));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_starve <= '0;
    end else if (w_gnt[REQ_DISP] && w_oth_req) begin
      r_starve <= (r_starve == StarveMax) ? r_starve : r_starve + 1'b1;
    end else begin
      r_starve <= '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bram_addr_o <= '0;
      bram_we_o   <= 1'b0;
      bram_din_o  <= '0;
      err_o       <= 1'b0;
      r_tag1      <= '0;
      r_tag2      <= '0;
      rvalid_o    <= '0;
      rdata_o     <= '0;
    end else begin
      if (|w_gnt) begin
        bram_addr_o <= w_addr;
        bram_din_o  <= w_din;
      end
      bram_we_o      <= (|w_gnt) & w_we & ~w_oor;
      err_o          <= (|w_gnt) & w_oor;
      r_tag1.req     <= w_gnt;
      r_tag1.is_read <= (|w_gnt) & ~w_we;
      r_tag1.oor     <= w_oor;
      r_tag2         <= r_tag1;
      rvalid_o       <= r_tag2.is_read ? r_tag2.req : '0;
      // Out-of-range reads still return a beat, but with zero data.
      rdata_o        <= (r_tag2.is_read && !r_tag2.oor) ? bram_dout_i : '0;
    end
  end

endmodule

// File: tb/tb_edge_bram_arbiter.sv
// Directed bench for edge_bram_arbiter: a behavioural BRAM, a per-cycle reference model of
// grants/returns, and literal checks pinning each scenario.
module tb_edge_bram_arbiter;
  import edge_mem_pkg::*;

  localparam int MaxStarve = 15;

  typedef struct {
    logic        we;
    logic [18:0] addr;
    logic [2:0]  data;
  } op_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [2:0]           req_i = '0;
  logic [2:0]           we_i = '0;
  logic [2:0][18:0]     addr_i = '0;
  logic [2:0][2:0]      wdata_i = '0;
  logic [2:0]           gnt_o;
  logic [2:0]           rvalid_o;
  logic [2:0]           rdata_o;
  logic                 err_o;
  logic [18:0]          bram_addr_o;
  logic                 bram_we_o;
  logic [2:0]           bram_din_o;
  logic [2:0]           bram_dout_i = '0;

  edge_bram_arbiter #(
    .WIDTH      (640),
    .HEIGHT     (480),
    .MAX_STARVE (MaxStarve)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req_i),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .gnt_o       (gnt_o),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .bram_addr_o (bram_addr_o),
    .bram_we_o   (bram_we_o),
    .bram_din_o  (bram_din_o),
    .bram_dout_i (bram_dout_i)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural write-first BRAM
  logic [2:0] mem [0:NPIX-1];
  always @(posedge clk) begin
    if (bram_addr_o < 19'(NPIX)) begin
      if (bram_we_o) begin
        mem[bram_addr_o] <= bram_din_o;
        bram_dout_i      <= bram_din_o;
      end else begin
        bram_dout_i <= mem[bram_addr_o];
      end
    end else begin
      bram_dout_i <= '0;
    end
  end

  // Requester driver: hold each op until it is granted
  op_t q0[$], q1[$], q2[$];
  logic [2:0] gnt_seen = '0;

  task automatic push(input int k, input logic we, input logic [18:0] a, input logic [2:0] d);
    op_t o;
    o.we = we; o.addr = a; o.data = d;
    case (k)
      0: q0.push_back(o);
      1: q1.push_back(o);
      default: q2.push_back(o);
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    if (rst) begin
      q0.delete(); q1.delete(); q2.delete();
    end else begin
      if (gnt_seen[0] && q0.size() > 0) void'(q0.pop_front());
      if (gnt_seen[1] && q1.size() > 0) void'(q1.pop_front());
      if (gnt_seen[2] && q2.size() > 0) void'(q2.pop_front());
    end
    req_i[0] = q0.size() > 0;
    req_i[1] = q1.size() > 0;
    req_i[2] = q2.size() > 0;
    if (q0.size() > 0) begin we_i[0] = q0[0].we; addr_i[0] = q0[0].addr; wdata_i[0] = q0[0].data; end
    if (q1.size() > 0) begin we_i[1] = q1[0].we; addr_i[1] = q1[0].addr; wdata_i[1] = q1[0].data; end
    if (q2.size() > 0) begin we_i[2] = q2[0].we; addr_i[2] = q2[0].addr; wdata_i[2] = q2[0].data; end
  end

  // Reference model and per-cycle comparison
  logic [2:0]  shadow [0:NPIX-1];
  logic [2:0]  exp_rv [int];
  logic [2:0]  exp_rd [int];
  logic        exp_err [int];
  logic        exp_we [int];
  logic [18:0] exp_addr [int];
  logic [2:0]  exp_din [int];
  int          starve = 0;
  int          pref = 0;

  logic [2:0] glog[$];
  int         gcyc[$];
  logic [2:0] rvlog[$];
  int         rvcyc[$];
  logic [2:0] rvdat[$];
  int         n_err = 0;
  int         n_bwr = 0;

  always @(negedge clk) begin
    logic [2:0] g;
    int idx;
    logic oth, oor;
    cyc++;
    gnt_seen = gnt_o;
    if (rst) begin
      chk("rst_gnt", 32'(gnt_o), 0);
      chk("rst_rvalid", 32'(rvalid_o), 0);
      chk("rst_rdata", 32'(rdata_o), 0);
      chk("rst_err", 32'(err_o), 0);
      chk("rst_bram", {bram_addr_o, bram_we_o, bram_din_o}, 0);
      exp_rv.delete(); exp_rd.delete(); exp_err.delete();
      exp_we.delete(); exp_addr.delete(); exp_din.delete();
      starve = 0;
      pref   = 0;
    end else begin
      chk("rvalid", 32'(rvalid_o), exp_rv.exists(cyc) ? 32'(exp_rv[cyc]) : 0);
      if (exp_rv.exists(cyc)) chk("rdata", 32'(rdata_o), 32'(exp_rd[cyc]));
      chk("err", 32'(err_o), exp_err.exists(cyc) ? 32'(exp_err[cyc]) : 0);
      chk("bram_we", 32'(bram_we_o), exp_we.exists(cyc) ? 32'(exp_we[cyc]) : 0);
      if (exp_addr.exists(cyc)) chk("bram_addr", 32'(bram_addr_o), 32'(exp_addr[cyc]));
      if (exp_we.exists(cyc) && exp_we[cyc]) chk("bram_din", 32'(bram_din_o), 32'(exp_din[cyc]));
      if (rvalid_o != 0) begin rvlog.push_back(rvalid_o); rvcyc.push_back(cyc); rvdat.push_back(rdata_o); end
      if (err_o) n_err++;
      if (bram_we_o) n_bwr++;

      oth = req_i[0] | req_i[1];
      g   = '0;
      idx = 0;
      if (req_i[2] && !(starve == MaxStarve && oth)) begin
        idx = 2;
        g   = 3'b100;
      end else if (oth) begin
        idx  = req_i[pref] ? pref : 1 - pref;
        g    = 3'(1 << idx);
        pref = 1 - idx;
      end
      chk("gnt", 32'(gnt_o), 32'(g));
      starve = (g == 3'b100 && oth) ? ((starve < MaxStarve) ? starve + 1 : starve) : 0;

      if (g != 0) begin
        glog.push_back(g);
        gcyc.push_back(cyc);
        oor = addr_i[idx] >= 19'(NPIX);
        exp_err[cyc+1]  = oor;
        exp_we[cyc+1]   = we_i[idx] && !oor;
        exp_addr[cyc+1] = addr_i[idx];
        exp_din[cyc+1]  = wdata_i[idx];
        if (we_i[idx]) begin
          if (!oor) shadow[addr_i[idx]] = wdata_i[idx];
        end else begin
          exp_rv[cyc+3] = g;
          exp_rd[cyc+3] = oor ? 3'b0 : shadow[addr_i[idx]];
        end
      end
    end
  end

  task automatic clear_logs();
    glog.delete(); gcyc.delete(); rvlog.delete(); rvcyc.delete(); rvdat.delete();
    n_err = 0;
    n_bwr = 0;
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk({name, "_timeout"}, 32'(t < 300), 1);
    repeat (6) @(negedge clk);
    #1;
  endtask

  initial begin
    int t;
    for (int i = 0; i < NPIX; i++) begin
      mem[i]    = 3'b000;
      shadow[i] = 3'b000;
    end
    mem[64100]    = 3'b101;
    shadow[64100] = 3'b101;

    repeat (3) @(negedge clk);
    chk("reset_gnt", 32'(gnt_o), 0);
    @(posedge clk); #2; rst = 1'b0;
    @(negedge clk); #1;

    // Single tracer read
    clear_logs();
    push(1, 1'b0, 19'd64100, 3'd0);
    wait_idle("p1");
    chk("p1_ngnt", glog.size(), 1);
    chk("p1_gnt", 32'(glog[0]), 32'b010);
    chk("p1_rvalid", 32'(rvlog[0]), 32'b010);
    chk("p1_latency", rvcyc[0] - gcyc[0], 3);
    chk("p1_rdata", 32'(rvdat[0]), 5);

    // Writer and tracer contending
    clear_logs();
    for (int i = 0; i < 4; i++) begin
      push(0, 1'b1, 19'(1000 + i), 3'(i + 1));
      push(1, 1'b0, 19'(2000 + i), 3'd0);
    end
    wait_idle("p2");
    chk("p2_ngnt", glog.size(), 8);
    chk("p2_g0", 32'(glog[0]), 32'b001);
    chk("p2_g1", 32'(glog[1]), 32'b010);
    chk("p2_g2", 32'(glog[2]), 32'b001);
    chk("p2_g3", 32'(glog[3]), 32'b010);
    chk("p2_nreads", rvlog.size(), 4);

    // Display hogging with tracer waiting
    clear_logs();
    for (int i = 0; i < 20; i++) push(2, 1'b0, 19'(i * 100), 3'd0);
    push(1, 1'b0, 19'd64100, 3'd0);
    wait_idle("p3");
    chk("p3_ngnt", glog.size(), 21);
    chk("p3_g14", 32'(glog[14]), 32'b100);
    chk("p3_g15", 32'(glog[15]), 32'b010);
    chk("p3_g16", 32'(glog[16]), 32'b100);
    chk("p3_nerr", n_err, 0);

    // Out-of-range read and write
    clear_logs();
    push(1, 1'b0, 19'd307200, 3'd0);
    push(1, 1'b1, 19'h7FFFF, 3'd7);
    wait_idle("p4");
    chk("p4_ngnt", glog.size(), 2);
    chk("p4_nerr", n_err, 2);
    chk("p4_nreads", rvlog.size(), 1);
    chk("p4_rdata", 32'(rvdat[0]), 0);
    chk("p4_nbramwr", n_bwr, 0);

    // Write then read of the same address
    clear_logs();
    push(0, 1'b1, 19'd640, 3'b011);
    push(1, 1'b0, 19'd640, 3'd0);
    wait_idle("p5");
    chk("p5_g0", 32'(glog[0]), 32'b001);
    chk("p5_g1", 32'(glog[1]), 32'b010);
    chk("p5_rdata", 32'(rvdat[0]), 3);

    // Reset while display reads are in flight
    clear_logs();
    for (int i = 0; i < 3; i++) push(2, 1'b0, 19'd64100, 3'd0);
    t = 0;
    while (glog.size() == 0 && t < 50) begin
      @(negedge clk); #1;
      t++;
    end
    chk("p6_first_gnt", 32'(glog.size() > 0), 1);
    @(posedge clk); #2; rst = 1'b1;
    @(negedge clk); #1;
    chk("p6_rst_rvalid", 32'(rvalid_o), 0);
    chk("p6_rst_bram_we", 32'(bram_we_o), 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #2; rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    chk("p6_no_rvalid", rvlog.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_bram_arbiter.md
# edge_bram_arbiter

Shares the single-port edge/bin BRAM (640x480 entries, 3 bits each) between three requesters: the edge-detector writer, the contour tracer and the VGA display reader. It grants one BRAM operation per cycle, pipelines read data back to the issuing requester with a fixed latency, and rejects out-of-frame addresses. It sits between the BRAM and every block that touches it, so no requester drives the BRAM directly.

## Interface
- WIDTH, 640, frame width in pixels
- HEIGHT, 480, frame height in pixels
- MAX_STARVE, 15, maximum consecutive display grants while another requester waits
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_i  in  3  per-requester request; [0]=edge writer, [1]=contour tracer, [2]=display
- we_i  in  3  per-requester write enable, qualified by req_i
- addr_i  in  3x19  per-requester address
- wdata_i  in  3x3  per-requester write data (bin value)
- gnt_o  out  3  one-hot grant, combinational, same cycle as accepted request
- rvalid_o  out  3  one-hot read-data-valid pulse
- rdata_o  out  3  read data, valid when any rvalid_o bit is set
- err_o  out  1  one-cycle pulse: an out-of-range operation was granted
- bram_addr_o  out  19  BRAM address (registered)
- bram_we_o  out  1  BRAM write enable (registered)
- bram_din_o  out  3  BRAM write data (registered)
- bram_dout_i  in  3  BRAM read data, 1 cycle after address

## Operation
- Requester holds req_i, we_i, addr_i, wdata_i stable until it sees gnt_o high; deasserts or presents the next op the cycle after.
- At most one gnt_o bit per cycle; gnt_o = 0 when req_i = 0.
- Priority: display (bit 2) wins whenever requesting, except when starve_cnt == MAX_STARVE and bit 0 or 1 is requesting; then the round-robin winner among bits 0/1 is granted and starve_cnt clears.
- starve_cnt: increments on a display grant while bit 0 or 1 requests; clears on any non-display grant or when bits 0/1 are idle. Saturates at MAX_STARVE.
- Round-robin among bits 0/1: rr_ptr names the preferred requester; after granting requester k, rr_ptr <= other requester. rr_ptr reset value 0.
- Range check: addr_i >= WIDTH*HEIGHT (307200) -> grant issued, bram_we_o forced 0, err_o pulses the cycle after grant; a read returns rvalid with rdata_o = 0.
- Writes produce no rvalid. A granted write followed by a read to the same address returns the new value (BRAM write-first; arbiter adds no forwarding).

## Timing
- Cycle N: gnt_o[k] high. N+1: bram_addr_o/we/din registered. N+2: bram_dout_i valid. N+3: rvalid_o[k] high, rdata_o registered. Read latency 3 cycles from grant.
- Tag pipeline: 3-stage shift of {requester one-hot, is_read, out_of_range}; back-to-back reads return in order, one per cycle.
- Reset values: gnt_o comb (0 during reset since all state cleared and outputs gated), rvalid_o=0, rdata_o=0, err_o=0, bram_addr_o=0, bram_we_o=0, bram_din_o=0, rr_ptr=0, starve_cnt=0.
- Reset mid-operation: tag pipeline cleared; in-flight reads never return rvalid; no BRAM write issued after rst rises.
- Simultaneous req of all three: display granted (starve permitting); tracer and writer wait.

## Structure
- edge_mem_pkg: WIDTH, HEIGHT, NPIX=307200, ADDR_W=19, BIN_W=3, requester indices REQ_EDGE=0, REQ_TRACE=1, REQ_DISP=2.
- One sub-module: rr_arb2 (two-way round-robin with pointer update); priority/starvation logic and tag pipeline stay in the top.

## Test plan
- Single tracer read addr 64100, bram holds 3'b101 -> gnt_o=3'b010 at N, rvalid_o=3'b010 and rdata_o=5 at N+3.
- Writer and tracer request every cycle -> grants alternate 001/010 starting with 001 after reset; no lost ops.
- Display requests continuously, tracer waiting -> 15 display grants, then one tracer grant, then display resumes; err_o never pulses.
- Tracer read at addr 307200 and write at 19'h7FFFF -> both granted, err_o pulses each, read returns rdata_o=0, BRAM content unchanged.
- Writer writes 3'b011 to addr 640, tracer reads 640 next cycle -> rdata_o=3.
- Three back-to-back display reads, rst asserted at N+1 -> no rvalid_o afterwards; all outputs 0 while rst high.
